pipeline_hazard_control: RTL and testbench
==========================================

# pipeline_hazard_control

Central hazard and stall controller for the five-stage pipeline. Each cycle it produces the per-latch command (enable, stall, bubble) that drives the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It resolves cache waits, load-use hazards, branch/jump flushes and halt, and keeps a saturating stall-cycle counter for performance runs.

## Interface
- Parameters:
- CNT_W, 32, width of stall_count
- Stage command encoding (2-bit, used on every *_state output):
- PIPE_ENABLE = 2'b00: latch loads its inputs.
- PIPE_STALL = 2'b01: latch holds its contents.
- PIPE_NOP = 2'b10: latch loads a bubble.
- 2'b11 is never driven.
- Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- ihit  in  1  instruction cache returned the instruction at the current PC this cycle
- dhit  in  1  data cache completed the MEM-stage access this cycle
- m_dREN, m_dWEN  in  1 each  load or store present in MEM
- m_pcsrc  in  2  nonzero means a taken branch or jump was resolved in MEM
- m_halt  in  1  halt instruction in MEM
- e_dREN  in  1  load in EX
- e_regWSEL  in  5  destination register of the instruction in EX
- d_rs, d_rt  in  5 each  source registers of the instruction in ID
- fd_state, de_state, em_state, mw_state  out  2 each  latch commands
- pc_en  out  1  PC register loads its next value
- halt_o  out  1  pipeline is halted
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- FSM states:
- RUN: normal operation.
- FLUSH_PEND: a redirect happened while a fetch was outstanding.
- HALTED: terminal state.
- Stage commands are combinational from the FSM state and the inputs. Only the state and stall_count are registered.
- In RUN, the first matching rule wins:
  1. m_halt=1: fd, de and em get NOP; mw gets ENABLE so the halt reaches WB; pc_en=0. Next state is HALTED.
  2. (m_dREN or m_dWEN) and dhit=0: fd, de and em get STALL; mw gets NOP so WB cannot repeat a write; pc_en=0.
  3. m_pcsrc!=0: fd, de and em get NOP; mw gets ENABLE; pc_en=1 and the PC loads the target. If ihit=0 in the same cycle, next state is FLUSH_PEND.
  4. Load-use hazard, defined as e_dREN=1 and e_regWSEL!=0 and (e_regWSEL==d_rs or e_regWSEL==d_rt): fd gets STALL; de gets NOP; em and mw get ENABLE; pc_en=0.
  5. ihit=0: fd gets NOP; de, em and mw get ENABLE; pc_en=0.
  6. Otherwise: all four stages get ENABLE; pc_en=1.
- In FLUSH_PEND:
  - Rules 1, 2 and 4 apply unchanged and take priority. If any of them fires, the state stays FLUSH_PEND (rule 1 still moves to HALTED).
  - Otherwise fd gets NOP, pc_en=0, and de, em and mw get ENABLE.
  - On the first cycle with ihit=1 (and no higher rule), the fetched instruction is discarded (fd gets NOP) and the next state is RUN.
  - A new m_pcsrc!=0 applies rule 3 and stays in FLUSH_PEND.
- In HALTED: all four stages get STALL, pc_en=0, halt_o=1. Only reset exits this state.
- stall_count increments on every cycle with pc_en=0 while the state is not HALTED. It saturates at all ones and never wraps.

## Timing
- While nRST=0, independent of the clock:
  - state is RUN and stall_count is 0
  - all four stage outputs are NOP
  - pc_en=0 and halt_o=0
- On the first rising edge after release, the outputs follow the RUN rules.
- Decision latency is zero cycles: the commands are valid in the same cycle as the inputs and are sampled by the latches at the next rising edge.
- State changes take effect on the rising edge after the triggering cycle. halt_o rises the cycle after m_halt is seen.
- Simultaneous events:
  - Halt beats a pending dcache miss, so a halt in MEM never has a memory op, by ISA.
  - A dcache miss beats a redirect: the redirect is held in MEM and taken on the dhit cycle.
  - Asserting reset in FLUSH_PEND or HALTED returns to RUN immediately.

## Test plan
- Reset, then ihit=1 with no hazards: all stage outputs are 00, pc_en=1, stall_count=0 over 10 cycles.
- m_dREN=1 and dhit=0 for 3 cycles, then dhit=1: fd, de and em are 01 and mw is 10 for 3 cycles, then all 00; stall_count=3.
- e_dREN=1, e_regWSEL=5, d_rt=5: fd=01, de=10, em=00, mw=00, pc_en=0 for one cycle. Repeat with e_regWSEL=0: no stall.
- m_pcsrc=2'b01 with ihit=0, then ihit low for 2 cycles, then high: on the redirect cycle fd, de and em are 10 and pc_en=1; the state is FLUSH_PEND; on the ihit cycle fd=10 and pc_en=0; the next cycle is in RUN.
- m_halt=1: that cycle mw=00 and the others are 10; afterwards all 01, halt_o=1 and stall_count frozen. Pulse nRST low: outputs are 10 and halt_o=0 immediately.
- Preload stall_count near saturation (CNT_W=4 build), then stall 20 cycles: the count holds at 4'hF.

Source files
------------

// File: rtl/pipeline_hazard_control.sv
// Hazard and stall controller for the five-stage pipeline: per-latch
// enable/stall/bubble commands, PC write enable, halt and a stall counter.
module pipeline_hazard_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             m_dREN,
  input  logic             m_dWEN,
  input  logic [1:0]       m_pcsrc,
  input  logic             m_halt,
  input  logic             e_dREN,
  input  logic [4:0]       e_regWSEL,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  output logic [1:0]       fd_state,
  output logic [1:0]       de_state,
  output logic [1:0]       em_state,
  output logic [1:0]       mw_state,
  output logic             pc_en,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] PIPE_ENABLE = 2'b00;
  localparam logic [1:0] PIPE_STALL  = 2'b01;
  localparam logic [1:0] PIPE_NOP    = 2'b10;

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH_PEND = 2'd1, HALTED = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic dmiss, redirect, lu_haz;

  assign dmiss    = (m_dREN | m_dWEN) & ~dhit;
  assign redirect = (m_pcsrc != 2'b00);
  assign lu_haz   = e_dREN & (e_regWSEL != 5'd0) &
                    ((e_regWSEL == d_rs) | (e_regWSEL == d_rt));

  always_comb begin
    fd_state = PIPE_ENABLE;
    de_state = PIPE_ENABLE;
    em_state = PIPE_ENABLE;
    mw_state = PIPE_ENABLE;
    pc_en    = 1'b1;
    state_d  = state_q;
    if (!nRST) begin
      // Reset must bubble every latch without waiting for a clock edge.
      fd_state = PIPE_NOP;
      de_state = PIPE_NOP;
      em_state = PIPE_NOP;
      mw_state = PIPE_NOP;
      pc_en    = 1'b0;
      state_d  = RUN;
    end else if (state_q == HALTED) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_STALL;
      mw_state = PIPE_STALL;
      pc_en    = 1'b0;
    end else if (m_halt) begin
      fd_state = PIPE_NOP;
      de_state = PIPE_NOP;
      em_state = PIPE_NOP;
      pc_en    = 1'b0;
      state_d  = HALTED;
    end else if (dmiss) begin
      // MW gets a bubble so WB does not retire the stalled op twice.
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_STALL;
      mw_state = PIPE_NOP;
      pc_en    = 1'b0;
    end else if (redirect) begin
      fd_state = PIPE_NOP;
      de_state = PIPE_NOP;
      em_state = PIPE_NOP;
      if (state_q == FLUSH_PEND || !ihit) state_d = FLUSH_PEND;
    end else if (lu_haz) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_NOP;
      pc_en    = 1'b0;
    end else if (state_q == FLUSH_PEND) begin
      // The outstanding fetch belongs to the squashed path; drop it.
      fd_state = PIPE_NOP;
      pc_en    = 1'b0;
      if (ihit) state_d = RUN;
    end else if (!ihit) begin
      fd_state = PIPE_NOP;
      pc_en    = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_en && state_q != HALTED && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halt_o      = (state_q == HALTED);
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Directed bench for pipeline_hazard_control: reset, stalls, load-use,
// redirect/flush, halt and counter saturation on a CNT_W=4 copy.
module tb_pipeline_hazard_control;

  logic       CLK, nRST;
  logic       ihit, dhit, m_dREN, m_dWEN, m_halt, e_dREN;
  logic [1:0] m_pcsrc;
  logic [4:0] e_regWSEL, d_rs, d_rt;

  logic [1:0]  fd_state, de_state, em_state, mw_state;
  logic        pc_en, halt_o;
  logic [31:0] stall_count;

  logic [1:0]  fd4, de4, em4, mw4;
  logic        pc4, halt4;
  logic [3:0]  cnt4;

  logic [8:0]  cmd;
  assign cmd = {fd_state, de_state, em_state, mw_state, pc_en};

  int n_chk  = 0;
  int n_pass = 0;

  pipeline_hazard_control #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .m_dREN(m_dREN),
    .m_dWEN(m_dWEN), .m_pcsrc(m_pcsrc), .m_halt(m_halt), .e_dREN(e_dREN),
    .e_regWSEL(e_regWSEL), .d_rs(d_rs), .d_rt(d_rt),
    .fd_state(fd_state), .de_state(de_state), .em_state(em_state),
    .mw_state(mw_state), .pc_en(pc_en), .halt_o(halt_o),
    .stall_count(stall_count)
  );

  pipeline_hazard_control #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .m_dREN(m_dREN),
    .m_dWEN(m_dWEN), .m_pcsrc(m_pcsrc), .m_halt(m_halt), .e_dREN(e_dREN),
    .e_regWSEL(e_regWSEL), .d_rs(d_rs), .d_rt(d_rt),
    .fd_state(fd4), .de_state(de4), .em_state(em4),
    .mw_state(mw4), .pc_en(pc4), .halt_o(halt4),
    .stall_count(cnt4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; m_dREN = 1'b0; m_dWEN = 1'b0; m_pcsrc = 2'b00;
    m_halt = 1'b0; e_dREN = 1'b0; e_regWSEL = 5'd0; d_rs = 5'd0; d_rt = 5'd0;
  endtask

  // Step to just after the next rising edge so new inputs land mid-cycle.
  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  // cmd encoding: {fd, de, em, mw, pc_en}
  localparam logic [8:0] C_RUN   = 9'b00_00_00_00_1;
  localparam logic [8:0] C_RST   = 9'b10_10_10_10_0;
  localparam logic [8:0] C_DMISS = 9'b01_01_01_10_0;
  localparam logic [8:0] C_LU    = 9'b01_10_00_00_0;
  localparam logic [8:0] C_IMISS = 9'b10_00_00_00_0;
  localparam logic [8:0] C_REDIR = 9'b10_10_10_00_1;
  localparam logic [8:0] C_HALT  = 9'b10_10_10_00_0;
  localparam logic [8:0] C_HLTD  = 9'b01_01_01_01_0;

  initial begin
    nRST = 1'b0;
    idle();
    #2;
    chk("rst_cmd",  {23'd0, cmd}, {23'd0, C_RST});
    chk("rst_halt", {31'd0, halt_o}, 32'd0);
    chk("rst_cnt",  stall_count, 32'd0);
    #20 nRST = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(); idle(); #1;
      chk("run_cmd", {23'd0, cmd}, {23'd0, C_RUN});
    end
    chk("run_cnt", stall_count, 32'd0);

    for (int i = 0; i < 3; i++) begin
      cyc(); m_dREN = 1'b1; dhit = 1'b0; #1;
      chk("dmiss_cmd", {23'd0, cmd}, {23'd0, C_DMISS});
    end
    cyc(); dhit = 1'b1; #1;
    chk("dhit_cmd", {23'd0, cmd}, {23'd0, C_RUN});
    chk("dmiss_cnt", stall_count, 32'd3);

    cyc(); idle(); e_dREN = 1'b1; e_regWSEL = 5'd5; d_rt = 5'd5; #1;
    chk("lu_rt", {23'd0, cmd}, {23'd0, C_LU});
    cyc(); e_regWSEL = 5'd0; d_rt = 5'd0; d_rs = 5'd0; #1;
    chk("lu_r0", {23'd0, cmd}, {23'd0, C_RUN});
    cyc(); e_regWSEL = 5'd7; d_rs = 5'd7; #1;
    chk("lu_rs", {23'd0, cmd}, {23'd0, C_LU});
    cyc(); e_dREN = 1'b0; #1;
    chk("lu_noload", {23'd0, cmd}, {23'd0, C_RUN});
    cyc(); idle(); ihit = 1'b0; #1;
    chk("imiss", {23'd0, cmd}, {23'd0, C_IMISS});
    cyc(); idle(); #1;
    chk("lu_cnt", stall_count, 32'd6);

    cyc(); m_pcsrc = 2'b01; ihit = 1'b0; #1;
    chk("redir", {23'd0, cmd}, {23'd0, C_REDIR});
    cyc(); m_pcsrc = 2'b00; #1;
    chk("fp_wait0", {23'd0, cmd}, {23'd0, C_IMISS});
    cyc(); #1;
    chk("fp_wait1", {23'd0, cmd}, {23'd0, C_IMISS});
    cyc(); ihit = 1'b1; #1;
    chk("fp_drop", {23'd0, cmd}, {23'd0, C_IMISS});
    cyc(); #1;
    chk("fp_back", {23'd0, cmd}, {23'd0, C_RUN});
    chk("fp_cnt", stall_count, 32'd9);

    cyc(); m_pcsrc = 2'b10; #1;
    chk("redir_hit", {23'd0, cmd}, {23'd0, C_REDIR});
    cyc(); m_pcsrc = 2'b00; #1;
    chk("redir_hit_run", {23'd0, cmd}, {23'd0, C_RUN});

    cyc(); m_dWEN = 1'b1; dhit = 1'b0; m_pcsrc = 2'b01; #1;
    chk("miss_vs_redir", {23'd0, cmd}, {23'd0, C_DMISS});
    cyc(); dhit = 1'b1; #1;
    chk("redir_on_dhit", {23'd0, cmd}, {23'd0, C_REDIR});
    cyc(); idle(); #1;
    chk("redir_cnt", stall_count, 32'd10);

    cyc(); m_halt = 1'b1; #1;
    chk("halt_cmd", {23'd0, cmd}, {23'd0, C_HALT});
    chk("halt_lag", {31'd0, halt_o}, 32'd0);
    cyc(); idle(); #1;
    chk("halted_cmd", {23'd0, cmd}, {23'd0, C_HLTD});
    chk("halted_o", {31'd0, halt_o}, 32'd1);
    chk("halted_cnt", stall_count, 32'd11);
    for (int i = 0; i < 4; i++) cyc();
    ihit = 1'b0; m_pcsrc = 2'b01; #1;
    chk("halted_hold", {23'd0, cmd}, {23'd0, C_HLTD});
    chk("halted_frz", stall_count, 32'd11);
    idle();
    nRST = 1'b0; #1;
    chk("rst2_cmd",  {23'd0, cmd}, {23'd0, C_RST});
    chk("rst2_halt", {31'd0, halt_o}, 32'd0);
    chk("rst2_cnt",  stall_count, 32'd0);
    #2 nRST = 1'b1;
    cyc(); #1;
    chk("rst2_run", {23'd0, cmd}, {23'd0, C_RUN});

    for (int i = 0; i < 20; i++) begin
      cyc(); ihit = 1'b0; #1;
      if (i == 14) chk("sat_e", {28'd0, cnt4}, 32'hE);
      if (i == 15) chk("sat_f", {28'd0, cnt4}, 32'hF);
    end
    cyc(); idle(); #1;
    chk("sat_hold", {28'd0, cnt4}, 32'hF);
    chk("wide_cnt", stall_count, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
